pe2_req_drain: RTL and testbench

//  Request-side counterpart of the two-LSB priority encoder (pe2_lsb). Accepts a request bit vector,

---
 rtl/pe2_req_drain.sv | 108 ++++++++++
 tb/tb_pe2_req_drain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pe2_req_drain.sv
// Request drain: holds a pending bit vector and offers its two lowest set bits per cycle.
// Optional PE2_REQ_DRAIN_MERGE_EN lets new requests merge into the pending vector while draining.
module pe2_req_drain #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WIDTH-1:0]     load_vec,
    output logic                 issue0_valid,
    output logic [IW-1:0]        issue0_index,
    output logic                 issue1_valid,
    output logic [IW-1:0]        issue1_index,
    input  logic                 issue_ready,
    output logic [WIDTH-1:0]     pending_vec,
    output logic                 busy,
    output logic                 drained,
    output logic [CNT_WIDTH-1:0] issued_count
);

    // state | meaning
    // IDLE  | pending_vec empty, waiting for a nonzero load
    // DRAIN | pending bits outstanding, offering up to two per cycle
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   low_mask;
    logic [WIDTH-1:0]   rest_vec;
    logic [WIDTH-1:0]   second_mask;
    logic [WIDTH-1:0]   issued_bits;
    logic [WIDTH-1:0]   next_pending;
    logic               issue_acc;
    logic               load_acc;
    logic [CNT_WIDTH:0] count_sum;
    logic [CNT_WIDTH:0] count_inc;

    // x & (x-1) strips the lowest set bit; the difference isolates it.
    assign rest_vec    = pending_vec & (pending_vec - WIDTH'(1));
    assign low_mask    = pending_vec & ~rest_vec;
    assign second_mask = rest_vec & ~(rest_vec & (rest_vec - WIDTH'(1)));

    assign issue0_valid = |pending_vec;
    assign issue1_valid = |rest_vec;

    always_comb begin
        issue0_index = '0;
        issue1_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (low_mask[i])    issue0_index = IW'(i);
            if (second_mask[i]) issue1_index = IW'(i);
        end
    end

`ifdef PE2_REQ_DRAIN_MERGE_EN
    assign load_ready = 1'b1;
`else
    assign load_ready = (state == IDLE);
`endif

    assign busy        = (state == DRAIN);
    assign load_acc    = load_valid & load_ready;
    assign issue_acc   = issue_ready & issue0_valid;
    assign issued_bits = issue_acc ? (low_mask | second_mask) : '0;

    always_comb begin
        next_pending = pending_vec & ~issued_bits;
        if (load_acc) next_pending = next_pending | load_vec;
    end

    assign count_inc = issue1_valid ? (CNT_WIDTH+1)'(2) : (CNT_WIDTH+1)'(1);
    assign count_sum = {1'b0, issued_count} + count_inc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            pending_vec  <= '0;
            drained      <= 1'b0;
            issued_count <= '0;
        end else begin
            drained <= 1'b0;
            case (state)
                IDLE: begin
                    // All-zero loads are accepted but leave the block idle.
                    if (load_acc && (load_vec != '0)) begin
                        state        <= DRAIN;
                        pending_vec  <= load_vec;
                        issued_count <= '0;
                    end
                end
                DRAIN: begin
                    pending_vec <= next_pending;
                    if (issue_acc) begin
                        issued_count <= count_sum[CNT_WIDTH] ? '1 : count_sum[CNT_WIDTH-1:0];
                    end
                    if (next_pending == '0) begin
                        state   <= IDLE;
                        drained <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe2_req_drain.sv
// Directed bench for pe2_req_drain (WIDTH=8); build with +define+PE2_REQ_DRAIN_MERGE_EN for the merge variant.
module tb_pe2_req_drain;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_vec;
    logic       issue0_valid;
    logic [2:0] issue0_index;
    logic       issue1_valid;
    logic [2:0] issue1_index;
    logic       issue_ready;
    logic [7:0] pending_vec;
    logic       busy;
    logic       drained;
    logic [7:0] issued_count;

    int checks = 0;
    int errors = 0;

    pe2_req_drain #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_vec     (load_vec),
        .issue0_valid (issue0_valid),
        .issue0_index (issue0_index),
        .issue1_valid (issue1_valid),
        .issue1_index (issue1_index),
        .issue_ready  (issue_ready),
        .pending_vec  (pending_vec),
        .busy         (busy),
        .drained      (drained),
        .issued_count (issued_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic v0, input logic [2:0] i0,
                             input logic v1, input logic [2:0] i1);
        chk({tag, "_v0"}, 32'(issue0_valid), 32'(v0));
        chk({tag, "_i0"}, 32'(issue0_index), 32'(i0));
        chk({tag, "_v1"}, 32'(issue1_valid), 32'(v1));
        chk({tag, "_i1"}, 32'(issue1_index), 32'(i1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pend"},  32'(pending_vec), 32'h00);
        chk_issue(tag, 1'b0, 3'd0, 1'b0, 3'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_lrdy"},  32'(load_ready), 32'd1);
        chk({tag, "_drn"},   32'(drained), 32'd0);
        chk({tag, "_cnt"},   32'(issued_count), 32'd0);
    endtask

    initial begin
        nRST        = 1'b0;
        load_valid  = 1'b0;
        load_vec    = 8'h00;
        issue_ready = 1'b0;
        step();
        step();
        nRST = 1'b1;
        step();

        // 1: async reset with a full pending vector
        load_valid = 1'b1; load_vec = 8'hFF;
        step();
        load_valid = 1'b0;
        chk("t1_loaded", 32'(pending_vec), 32'hFF);
        #2 nRST = 1'b0;
        #1;
        chk_reset_vals("t1_rst");
        step();
        nRST = 1'b1;
        step();

        // all-zero load: accepted, no state change, no pulse
        load_valid = 1'b1; load_vec = 8'h00;
        step();
        load_valid = 1'b0;
        chk("t0_busy", 32'(busy), 32'd0);
        step();
        chk("t0_drn", 32'(drained), 32'd0);

        // 2: two-per-cycle drain of 1011_0100
        load_valid = 1'b1; load_vec = 8'b1011_0100; issue_ready = 1'b1;
        step();
        load_valid = 1'b0;
        chk_issue("t2_c1", 1'b1, 3'd2, 1'b1, 3'd4);
        chk("t2_c1_busy", 32'(busy), 32'd1);
        chk("t2_c1_cnt", 32'(issued_count), 32'd0);
        step();
        chk_issue("t2_c2", 1'b1, 3'd5, 1'b1, 3'd7);
        chk("t2_c2_cnt", 32'(issued_count), 32'd2);
        step();
        chk("t2_c3_pend", 32'(pending_vec), 32'h00);
        chk("t2_c3_drn", 32'(drained), 32'd1);
        chk("t2_c3_busy", 32'(busy), 32'd0);
        chk("t2_c3_cnt", 32'(issued_count), 32'd4);
        step();
        chk("t2_c4_drn", 32'(drained), 32'd0);
        chk("t2_c4_cnt", 32'(issued_count), 32'd4);

        // 3: single bit, slot 1 invalid
        issue_ready = 1'b0;
        load_valid = 1'b1; load_vec = 8'b1000_0000;
        step();
        load_valid = 1'b0;
        chk_issue("t3", 1'b1, 3'd7, 1'b0, 3'd0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t3_drn", 32'(drained), 32'd1);
        chk("t3_cnt", 32'(issued_count), 32'd1);
        chk("t3_pend", 32'(pending_vec), 32'h00);

        // 4: consumer stall holds outputs
        load_valid = 1'b1; load_vec = 8'b0000_0110;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_issue("t4_hold", 1'b1, 3'd1, 1'b1, 3'd2);
            chk("t4_pend", 32'(pending_vec), 32'h06);
            chk("t4_cnt", 32'(issued_count), 32'd0);
            step();
        end

        // 5: load offered while busy (pending 0000_0110)
`ifdef PE2_REQ_DRAIN_MERGE_EN
        load_valid = 1'b1; load_vec = 8'h01; issue_ready = 1'b1;
        #1;
        chk("t5m_lrdy", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        chk("t5m_pend", 32'(pending_vec), 32'h01);
        chk("t5m_busy", 32'(busy), 32'd1);
        chk("t5m_cnt", 32'(issued_count), 32'd2);
        chk("t5m_drn", 32'(drained), 32'd0);
        step();
        issue_ready = 1'b0;
        chk("t5m_pend2", 32'(pending_vec), 32'h00);
        chk("t5m_drn2", 32'(drained), 32'd1);
        chk("t5m_cnt2", 32'(issued_count), 32'd3);
        // reissue of a bit in the same cycle it is cleared keeps it set
        load_valid = 1'b1; load_vec = 8'b0000_0011;
        step();
        load_vec = 8'b0000_0001; issue_ready = 1'b1;
        step();
        load_valid = 1'b0; issue_ready = 1'b0;
        chk("t5m_reload", 32'(pending_vec), 32'h01);
        chk("t5m_busy3", 32'(busy), 32'd1);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
`else
        load_valid = 1'b1; load_vec = 8'h01; issue_ready = 1'b0;
        #1;
        chk("t5_lrdy", 32'(load_ready), 32'd0);
        step();
        chk("t5_pend", 32'(pending_vec), 32'h06);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t5_pend2", 32'(pending_vec), 32'h00);
        chk("t5_drn", 32'(drained), 32'd1);
        chk("t5_lrdy2", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        chk("t5_stalled_load", 32'(pending_vec), 32'h01);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_cnt", 32'(issued_count), 32'd0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t5_cnt2", 32'(issued_count), 32'd1);
`endif
        chk("t5_idle", 32'(busy), 32'd0);

        // 6: async reset mid-drain
        load_valid = 1'b1; load_vec = 8'hF0;
        step();
        load_valid = 1'b0;
        chk("t6_pend", 32'(pending_vec), 32'hF0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t6_mid", 32'(pending_vec), 32'hC0);
        chk("t6_mid_cnt", 32'(issued_count), 32'd2);
        #2 nRST = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        step();
        nRST = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
